// File: rtl/pinball_game_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pinball_pkg
// Shared constants for the pinball game controller: round FSM state codes,
// state vector width and the width of the ball counter. The state codes are
// visible on the controller's state output, so they are fixed numeric values.
// -----------------------------------------------------------------------------
package pinball_pkg;

   localparam int STATE_W = 3;
   localparam int BALL_W  = 4;

   localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
   localparam logic [STATE_W-1:0] ST_ARMED  = 3'd1;
   localparam logic [STATE_W-1:0] ST_LAUNCH = 3'd2;
   localparam logic [STATE_W-1:0] ST_SETTLE = 3'd3;
   localparam logic [STATE_W-1:0] ST_OVER   = 3'd4;

   // Larger of two cycle counts; sizes the shared launch/settle counter.
   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pinball_game_ctrl_if.sv
// -----------------------------------------------------------------------------
// pinball_game_ctrl_if
// Bundles everything between the game controller and its neighbours: the
// one-pulsed buttons, hole sensors and group select coming in, and the state,
// score, BCD digits and event pulses going out.
//   master : the button/sensor side (drives start_p, round_p, abort_p, holes,
//            sel_group; observes all status outputs)
//   slave  : the controller itself
// Handshake: bcd_valid is a level qualifier with no ready. While it is high,
// score_bcd is the decimal image of score; it drops on the cycle score
// changes and rises again once the new digits are in place.
// -----------------------------------------------------------------------------
interface pinball_game_ctrl_if #(
   parameter int N_HOLES  = 8,
   parameter int SCORE_W  = 15,
   parameter int N_DIGITS = 4
);
   localparam int SEL_W = (N_HOLES > 1) ? $clog2(N_HOLES) : 1;

   logic                  start_p;
   logic                  round_p;
   logic                  abort_p;
   logic [N_HOLES-1:0]    holes;
   logic [SEL_W-1:0]      sel_group;

   logic [2:0]            state;
   logic [3:0]            balls_left;
   logic [SEL_W-1:0]      last_hole;
   logic [SCORE_W-1:0]    score;
   logic [4*N_DIGITS-1:0] score_bcd;
   logic                  bcd_valid;
   logic                  match_p;
   logic                  lost_p;
   logic                  win;

   modport master (
      output start_p, round_p, abort_p, holes, sel_group,
      input  state, balls_left, last_hole, score, score_bcd, bcd_valid,
             match_p, lost_p, win
   );

   modport slave (
      input  start_p, round_p, abort_p, holes, sel_group,
      output state, balls_left, last_hole, score, score_bcd, bcd_valid,
             match_p, lost_p, win
   );

endinterface

// File: rtl/pinball_game_ctrl_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble binary-to-BCD converter, one input bit per cycle.
//   clk, rst_n : clock, async active-low reset
//   start      : load bin_in and begin; also aborts a conversion in flight
//   bin_in     : binary value (BIN_W bits)
//   busy       : conversion in progress
//   done       : bcd_out holds the result of the last completed conversion
//   bcd_out    : N_DIGITS BCD digits, digit 0 in the low nibble
// Timing: start sampled at edge E0, BIN_W shift edges follow, bcd_out and
// done update on edge E0+BIN_W+1.
// -----------------------------------------------------------------------------
module bin2bcd_seq #(
   parameter int BIN_W    = 15,
   parameter int N_DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*N_DIGITS-1:0] bcd_out
);
   localparam int BCD_W = 4 * N_DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);

   logic [BIN_W-1:0] bin_sh_q,  bin_sh_d;
   logic [BCD_W-1:0] bcd_sh_q,  bcd_sh_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic             busy_q,    busy_d;
   logic             done_q,    done_d;
   logic [BCD_W-1:0] bcd_out_q, bcd_out_d;
   logic [BCD_W-1:0] adj;

   always_comb begin
      bin_sh_d  = bin_sh_q;
      bcd_sh_d  = bcd_sh_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      done_d    = done_q;
      bcd_out_d = bcd_out_q;

      // Add-3 correction on every digit that would overflow on the next shift.
      adj = bcd_sh_q;
      for (int d = 0; d < N_DIGITS; d++) begin
         if (adj[4*d +: 4] >= 4'd5) adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
      end

      if (start) begin
         // A new start always wins, so a partial result is simply dropped.
         bin_sh_d = bin_in;
         bcd_sh_d = '0;
         cnt_d    = CNT_W'(BIN_W);
         busy_d   = 1'b1;
         done_d   = 1'b0;
      end else if (busy_q) begin
         if (cnt_q != '0) begin
            bcd_sh_d = {adj[BCD_W-2:0], bin_sh_q[BIN_W-1]};
            bin_sh_d = {bin_sh_q[BIN_W-2:0], 1'b0};
            cnt_d    = cnt_q - CNT_W'(1);
         end else begin
            bcd_out_d = bcd_sh_q;
            busy_d    = 1'b0;
            done_d    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_sh_q  <= '0;
         bcd_sh_q  <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b1;
         bcd_out_q <= '0;
      end else begin
         bin_sh_q  <= bin_sh_d;
         bcd_sh_q  <= bcd_sh_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         bcd_out_q <= bcd_out_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign bcd_out = bcd_out_q;

endmodule

// File: rtl/pinball_game_ctrl.sv
// -----------------------------------------------------------------------------
// pinball_game_ctrl
// Round FSM, ball budget, hole capture, scoring and BCD score for a pinball
// table. Inputs are already debounced/one-pulsed except holes, which are raw.
//   clk, rst_n : clock, async active-low reset (sync release assumed upstream)
//   bus        : pinball_game_ctrl_if.slave
//     in : start_p, round_p, abort_p (1-cycle pulses), holes (raw sensors),
//          sel_group (currently lit group)
//     out: state (FSM code, also the debug view), balls_left, last_hole,
//          score, score_bcd/bcd_valid, match_p, lost_p, win
// Round flow: IDLE -start-> ARMED -round-> LAUNCH -hole/timeout-> SETTLE
//   -SETTLE_CYC-> ARMED or OVER -start-> IDLE. abort_p returns to IDLE from
//   anywhere and wins over start_p, which in turn wins over round_p.
// -----------------------------------------------------------------------------
module pinball_game_ctrl
   import pinball_pkg::*;
#(
   parameter int N_HOLES    = 8,
   parameter int N_BALLS    = 8,
   parameter int SETTLE_CYC = 200_000_000,
   parameter int LAUNCH_CYC = 500_000_000,
   parameter int HOLE_PTS   = 10,
   parameter int MATCH_MULT = 3,
   parameter int SCORE_W    = 15,
   parameter int SCORE_MAX  = 9999,
   parameter int WIN_SCORE  = 300,
   parameter int N_DIGITS   = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   pinball_game_ctrl_if.slave bus
);
   localparam int SEL_W = (N_HOLES > 1) ? $clog2(N_HOLES) : 1;
   localparam int CNT_W = $clog2(max2(SETTLE_CYC, LAUNCH_CYC));
   localparam int ADD_W = SCORE_W + 4;
   localparam int SUM_W = SCORE_W + 5;

   logic [N_HOLES-1:0] holes_s1_q, holes_s1_d;
   logic [N_HOLES-1:0] holes_s2_q, holes_s2_d;
   logic [STATE_W-1:0] state_q,    state_d;
   logic [CNT_W-1:0]   cnt_q,      cnt_d;
   logic [BALL_W-1:0]  balls_q,    balls_d;
   logic [SCORE_W-1:0] score_q,    score_d;
   logic [SEL_W-1:0]   last_q,     last_d;
   logic               match_q,    match_d;
   logic               lost_q,     lost_d;

   logic               hit;
   logic [SEL_W-1:0]   hit_idx;
   logic               hit_match;
   logic [ADD_W-1:0]   addend;
   logic [SUM_W-1:0]   sum;
   logic [SCORE_W-1:0] score_hit;
   logic [BALL_W-1:0]  balls_dec;

   logic               conv_start;
   logic               conv_busy;
   logic               conv_done;

   // Two-flop synchroniser for the asynchronous hole sensors.
   assign holes_s1_d = bus.holes;
   assign holes_s2_d = holes_s1_q;

   // Priority encoder: scan from the top so the lowest set index ends up last.
   always_comb begin
      hit     = |holes_s2_q;
      hit_idx = '0;
      for (int i = N_HOLES - 1; i >= 0; i--) begin
         if (holes_s2_q[i]) hit_idx = SEL_W'(i);
      end
   end

   // Score datapath. Widened so the addend and sum cannot wrap before clamping.
   always_comb begin
      hit_match = (hit_idx == bus.sel_group);
      addend    = ADD_W'(HOLE_PTS) * (ADD_W'(hit_idx) + ADD_W'(1));
      if (hit_match) addend = addend * ADD_W'(MATCH_MULT);
      sum       = SUM_W'(score_q) + SUM_W'(addend);
      score_hit = (sum > SUM_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : sum[SCORE_W-1:0];
      balls_dec = (balls_q != '0) ? balls_q - BALL_W'(1) : balls_q;
   end

   // Round FSM. cnt_q is shared by LAUNCH and SETTLE and cleared on every
   // state change, so each state times itself from zero.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      balls_d = balls_q;
      score_d = score_q;
      last_d  = last_q;
      match_d = 1'b0;
      lost_d  = 1'b0;

      if (bus.abort_p) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         balls_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start_p) begin
                  state_d = ST_ARMED;
                  cnt_d   = '0;
                  score_d = '0;
                  balls_d = BALL_W'(N_BALLS);
               end
            end
            ST_ARMED: begin
               if (bus.round_p) begin
                  state_d = ST_LAUNCH;
                  cnt_d   = '0;
               end
            end
            ST_LAUNCH: begin
               // A hole seen on the timeout cycle still counts as a capture.
               if (hit) begin
                  state_d = ST_SETTLE;
                  cnt_d   = '0;
                  balls_d = balls_dec;
                  last_d  = hit_idx;
                  score_d = score_hit;
                  match_d = hit_match;
               end else if (cnt_q == CNT_W'(LAUNCH_CYC - 1)) begin
                  state_d = ST_SETTLE;
                  cnt_d   = '0;
                  balls_d = balls_dec;
                  lost_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_SETTLE: begin
               if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                  state_d = (balls_q != '0) ? ST_ARMED : ST_OVER;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_OVER: begin
               // Score stays on display through IDLE until the next game starts.
               if (bus.start_p) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         holes_s1_q <= '0;
         holes_s2_q <= '0;
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         balls_q    <= '0;
         score_q    <= '0;
         last_q     <= '0;
         match_q    <= 1'b0;
         lost_q     <= 1'b0;
      end else begin
         holes_s1_q <= holes_s1_d;
         holes_s2_q <= holes_s2_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         balls_q    <= balls_d;
         score_q    <= score_d;
         last_q     <= last_d;
         match_q    <= match_d;
         lost_q     <= lost_d;
      end
   end

   // Any score change restarts the converter on the same edge score moves.
   assign conv_start = (score_d != score_q);

   bin2bcd_seq #(
      .BIN_W    (SCORE_W),
      .N_DIGITS (N_DIGITS)
   ) u_bcd (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (conv_start),
      .bin_in  (score_d),
      .busy    (conv_busy),
      .done    (conv_done),
      .bcd_out (bus.score_bcd)
   );

   assign bus.state      = state_q;
   assign bus.balls_left = balls_q;
   assign bus.last_hole  = last_q;
   assign bus.score      = score_q;
   assign bus.bcd_valid  = conv_done & ~conv_busy;
   assign bus.match_p    = match_q;
   assign bus.lost_p     = lost_q;
   assign bus.win        = (state_q == ST_OVER) && (score_q >= SCORE_W'(WIN_SCORE));

endmodule

// File: tb/tb_pinball_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pinball_game_ctrl
// Drives whole games through pinball_game_ctrl with short SETTLE/LAUNCH
// timers and a lowered SCORE_MAX so saturation is reachable. A game-level
// model (lowest set hole, points table, clamp, ball budget) predicts every
// state transition, including the cycle it should happen on; a monitor pops
// those predictions whenever the DUT changes state and also checks the BCD
// digits each time bcd_valid rises.
// -----------------------------------------------------------------------------
module tb_pinball_game_ctrl;

   localparam int N_HOLES    = 8;
   localparam int N_BALLS    = 8;
   localparam int SETTLE_CYC = 20;
   localparam int LAUNCH_CYC = 50;
   localparam int HOLE_PTS   = 10;
   localparam int MATCH_MULT = 3;
   localparam int SCORE_W    = 15;
   localparam int SCORE_MAX  = 600;
   localparam int WIN_SCORE  = 300;
   localparam int N_DIGITS   = 4;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ARMED  = 3'd1;
   localparam logic [2:0] S_LAUNCH = 3'd2;
   localparam logic [2:0] S_SETTLE = 3'd3;
   localparam logic [2:0] S_OVER   = 3'd4;

   typedef struct packed {
      logic [31:0] stamp;
      logic [2:0]  st;
      logic [3:0]  balls;
      logic [14:0] score;
      logic [2:0]  last;
      logic        match;
      logic        lost;
      logic        win;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   vectors;
   int   miscompares;
   bit   mon_en;
   exp_t exp_q[$];

   // game model
   logic [2:0] st_m;
   int         score_m;
   int         balls_m;
   int         last_m;

   pinball_game_ctrl_if #(.N_HOLES(N_HOLES), .SCORE_W(SCORE_W), .N_DIGITS(N_DIGITS)) bus ();

   pinball_game_ctrl #(
      .N_HOLES    (N_HOLES),
      .N_BALLS    (N_BALLS),
      .SETTLE_CYC (SETTLE_CYC),
      .LAUNCH_CYC (LAUNCH_CYC),
      .HOLE_PTS   (HOLE_PTS),
      .MATCH_MULT (MATCH_MULT),
      .SCORE_W    (SCORE_W),
      .SCORE_MAX  (SCORE_MAX),
      .WIN_SCORE  (WIN_SCORE),
      .N_DIGITS   (N_DIGITS)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- helpers ----------------
   function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endfunction

   function automatic int lowest(input logic [7:0] p);
      int r;
      r = -1;
      for (int i = 7; i >= 0; i--) if (p[i]) r = i;
      return r;
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int          x;
      x = v;
      r = '0;
      for (int d = 0; d < 4; d++) begin
         r[4*d +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic void push(input int stamp, input bit mt, input bit lt);
      exp_t e;
      e.stamp = 32'(stamp);
      e.st    = st_m;
      e.balls = 4'(balls_m);
      e.score = 15'(score_m);
      e.last  = 3'(last_m);
      e.match = mt;
      e.lost  = lt;
      e.win   = (st_m == S_OVER) && (score_m >= WIN_SCORE);
      exp_q.push_back(e);
   endfunction

   // ---------------- driver tasks (all entered at a negedge) ----------------
   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic do_start();
      int n;
      n = cyc;
      bus.start_p = 1'b1;
      if (st_m == S_IDLE) begin
         st_m    = S_ARMED;
         score_m = 0;
         balls_m = N_BALLS;
         push(n + 1, 1'b0, 1'b0);
      end else if (st_m == S_OVER) begin
         st_m = S_IDLE;
         push(n + 1, 1'b0, 1'b0);
      end
      @(negedge clk);
      bus.start_p = 1'b0;
   endtask

   task automatic do_abort(input bit with_round);
      int n;
      n = cyc;
      bus.abort_p = 1'b1;
      bus.round_p = with_round;
      st_m    = S_IDLE;
      balls_m = 0;
      push(n + 1, 1'b0, 1'b0);
      @(negedge clk);
      bus.abort_p = 1'b0;
      bus.round_p = 1'b0;
   endtask

   // One ball: round_p, then either a hole pattern dly cycles later or no
   // hole at all (timeout). abort_k>0 aborts k cycles into SETTLE.
   task automatic play_ball(input logic [7:0] pat, input int sel, input int dly, input int abort_k);
      int n, cap, idx, pts;
      bit mt;
      bus.sel_group = 3'(sel);
      n = cyc;
      bus.round_p = 1'b1;
      st_m = S_LAUNCH;
      push(n + 1, 1'b0, 1'b0);
      @(negedge clk);
      bus.round_p = 1'b0;
      if (pat != 8'h00) begin
         wait_until(n + 1 + dly);
         bus.holes = pat;
         cap = n + 1 + dly + 3;
         idx = lowest(pat);
         mt  = (idx == sel);
         pts = HOLE_PTS * (idx + 1) * (mt ? MATCH_MULT : 1);
         score_m = (score_m + pts > SCORE_MAX) ? SCORE_MAX : score_m + pts;
         last_m  = idx;
         if (balls_m > 0) balls_m--;
         st_m = S_SETTLE;
         push(cap, mt, 1'b0);
      end else begin
         cap = n + 1 + LAUNCH_CYC;
         if (balls_m > 0) balls_m--;
         st_m = S_SETTLE;
         push(cap, 1'b0, 1'b1);
      end
      wait_until(cap);
      bus.holes = '0;
      if (abort_k != 0) begin
         wait_until(cap + abort_k);
         do_abort(1'b0);
      end else begin
         st_m = (balls_m > 0) ? S_ARMED : S_OVER;
         push(cap + SETTLE_CYC, 1'b0, 1'b0);
         wait_until(cap + SETTLE_CYC);
      end
   endtask

   task automatic rand_ball(input int abort_k);
      logic [7:0] pat;
      int sel;
      pat = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      sel = $urandom_range(0, 7);
      if (pat != 8'h00 && $urandom_range(0, 1) == 1) sel = lowest(pat);
      play_ball(pat, sel, $urandom_range(0, 47), abort_k);
   endtask

   task automatic reset_in_launch();
      int n, m;
      n = cyc;
      bus.round_p = 1'b1;
      st_m = S_LAUNCH;
      push(n + 1, 1'b0, 1'b0);
      @(negedge clk);
      bus.round_p = 1'b0;
      repeat (5) @(negedge clk);
      m = cyc;
      #2;
      rst_n   = 1'b0;
      st_m    = S_IDLE;
      score_m = 0;
      balls_m = 0;
      last_m  = 0;
      push(m + 1, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic [2:0] prev_st;
      logic       valid_prev;
      int         conf_score;
      int         chg_cyc;
      exp_t       e, o;
      prev_st    = S_IDLE;
      valid_prev = 1'b1;
      conf_score = 0;
      chg_cyc    = 0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (bus.state != prev_st) begin
               o.stamp = 32'(cyc);
               o.st    = bus.state;
               o.balls = bus.balls_left;
               o.score = bus.score;
               o.last  = bus.last_hole;
               o.match = bus.match_p;
               o.lost  = bus.lost_p;
               o.win   = bus.win;
               vectors++;
               if (exp_q.size() == 0) begin
                  miscompares++;
                  $display("FAIL trans: unexpected change to state %0d at cycle %0d", o.st, cyc);
               end else begin
                  e = exp_q.pop_front();
                  if (o !== e) begin
                     miscompares++;
                     $display("FAIL trans: got cyc=%0d st=%0d balls=%0d score=%0d last=%0d m=%0d l=%0d win=%0d, expected cyc=%0d st=%0d balls=%0d score=%0d last=%0d m=%0d l=%0d win=%0d",
                              o.stamp, o.st, o.balls, o.score, o.last, o.match, o.lost, o.win,
                              e.stamp, e.st, e.balls, e.score, e.last, e.match, e.lost, e.win);
                  end
                  if (int'(e.score) != conf_score) begin
                     chg_cyc = cyc;
                     if (rst_n) check("bcd_valid_drop", 32'(bus.bcd_valid), 32'd0);
                  end
                  conf_score = int'(e.score);
               end
               prev_st = bus.state;
            end else begin
               check("idle_pulses", 32'({bus.match_p, bus.lost_p}), 32'd0);
            end
            if (bus.bcd_valid && !valid_prev) begin
               check("score_bcd", 32'(bus.score_bcd), 32'(to_bcd(conf_score)));
               if (rst_n) check("bcd_latency", 32'(cyc - chg_cyc), 32'(SCORE_W + 1));
            end
            valid_prev = bus.bcd_valid;
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      vectors       = 0;
      miscompares   = 0;
      mon_en        = 1'b0;
      rst_n         = 1'b0;
      bus.start_p   = 1'b0;
      bus.round_p   = 1'b0;
      bus.abort_p   = 1'b0;
      bus.holes     = '0;
      bus.sel_group = '0;
      st_m = S_IDLE; score_m = 0; balls_m = 0; last_m = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      check("rst_state",     32'(bus.state),      32'(S_IDLE));
      check("rst_balls",     32'(bus.balls_left), 32'd0);
      check("rst_score",     32'(bus.score),      32'd0);
      check("rst_last_hole", 32'(bus.last_hole),  32'd0);
      check("rst_bcd",       32'(bus.score_bcd),  32'd0);
      check("rst_bcd_valid", 32'(bus.bcd_valid),  32'd1);
      check("rst_pulses",    32'({bus.match_p, bus.lost_p, bus.win}), 32'd0);
      mon_en = 1'b1;

      // Game 1: directed sequence ending in saturation and a win.
      do_start();
      play_ball(8'b0000_0100, 5, 3, 0);   // hole 2, no match: 30
      play_ball(8'b0000_1000, 3, 5, 0);   // hole 3 matched: +120
      play_ball(8'b1001_0000, 0, 2, 0);   // simultaneous, hole 4: +50
      play_ball(8'b0000_0000, 0, 0, 0);   // lost ball
      play_ball(8'b0000_0010, 0, 47, 0);  // hole lands on the timeout cycle
      play_ball(8'b1000_0000, 7, $urandom_range(0, 47), 0);
      play_ball(8'b1000_0000, 7, $urandom_range(0, 47), 0);  // clamps at SCORE_MAX
      rand_ball(0);                        // last ball -> OVER with win
      do_start();                          // OVER -> IDLE, score kept
      do_start();                          // IDLE -> ARMED, score cleared

      // Game 2: capture right after the clear restarts the BCD conversion,
      // then abort on the final SETTLE cycle.
      play_ball(8'b0100_0000, 6, 0, 0);
      rand_ball(0);
      rand_ball(19);

      // Abort coincident with round_p: abort wins.
      do_start();
      repeat (20) @(negedge clk);
      do_abort(1'b1);

      // Random abort point in SETTLE.
      do_start();
      repeat (20) @(negedge clk);
      rand_ball(0);
      rand_ball($urandom_range(1, 18));

      // Reset while the ball is in flight.
      do_start();
      repeat (20) @(negedge clk);
      rand_ball(0);
      reset_in_launch();

      // Full random game.
      do_start();
      for (int b = 0; b < N_BALLS; b++) rand_ball(0);
      do_start();

      repeat (30) @(negedge clk);
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Hard stop so a wedged run still reports.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not finish by cycle %0d", cyc);
      miscompares++;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
